// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: clears the 16-entry GPR file after reset, then round-robin arbitrates ALU/load write-back.
module gpr_wb_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [1:0]        grant,
  output logic              init_done
);
  typedef enum logic {INIT, RUN} state_t;
  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              ptr;
  logic              run;
  // ptr: 0 favours ALU, 1 favours MEM; readies look only at VALIDs and ptr
  assign run       = (state == RUN) && !rst;
  assign alu_ready = run && alu_valid && (!mem_valid || !ptr);
  assign mem_ready = run && mem_valid && (!alu_valid || ptr);
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      cnt       <= '0;
      ptr       <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      grant     <= 2'b00;
      init_done <= 1'b0;
    end else if (state == INIT) begin
      wr_en   <= 1'b1;
      wr_addr <= cnt;
      wr_data <= '0;
      grant   <= 2'b00;
      cnt     <= cnt + 1'b1;
      if (cnt == ADDR_W'(NUM_REGS - 1)) begin
        state     <= RUN;
        init_done <= 1'b1;
      end
    end else begin
      wr_en <= alu_ready || mem_ready;
      grant <= {mem_ready, alu_ready};
      if (alu_ready) begin
        wr_addr <= alu_addr;
        wr_data <= alu_data;
        ptr     <= 1'b1;
      end else if (mem_ready) begin
        wr_addr <= mem_addr;
        wr_data <= mem_data;
        ptr     <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb_gpr_wb_arbiter: directed vector table plus init and mid-run reset sequences.
module tb_gpr_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid;
  logic [3:0]  alu_addr, mem_addr;
  logic [15:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, wr_en, init_done;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  grant;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  gpr_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .grant(grant), .init_done(init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [3:0]  aa;
    logic [15:0] ad;
    logic        mv;
    logic [3:0]  ma;
    logic [15:0] md;
    logic        ear;
    logic        emr;
    logic        ewe;
    logic [3:0]  ewa;
    logic [15:0] ewd;
    logic [1:0]  eg;
  } vec_t;
  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_init_seq();
    for (int i = 0; i < 16; i++) begin
      #1;
      chk($sformatf("init%0d_alu_ready", i), 32'(alu_ready), 0);
      chk($sformatf("init%0d_mem_ready", i), 32'(mem_ready), 0);
      tick();
      if (i == 15) begin
        alu_valid = 1'b0;
        mem_valid = 1'b0;
      end
      chk($sformatf("init%0d_wr_en", i), 32'(wr_en), 1);
      chk($sformatf("init%0d_wr_addr", i), 32'(wr_addr), 32'(i));
      chk($sformatf("init%0d_wr_data", i), 32'(wr_data), 0);
      chk($sformatf("init%0d_grant", i), 32'(grant), 0);
      chk($sformatf("init%0d_init_done", i), 32'(init_done), (i == 15) ? 1 : 0);
    end
  endtask

  initial begin
    // ptr starts at ALU after init
    vecs[0]  = '{1, 4'd3, 16'hBEEF, 0, 4'd0, 16'h0000, 1, 0, 1, 4'd3, 16'hBEEF, 2'b01};
    vecs[1]  = '{0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0, 0, 4'd3, 16'hBEEF, 2'b00};
    vecs[2]  = '{0, 4'd0, 16'h0000, 1, 4'd7, 16'h7777, 0, 1, 1, 4'd7, 16'h7777, 2'b10};
    vecs[3]  = '{1, 4'd1, 16'h1111, 1, 4'd2, 16'h2222, 1, 0, 1, 4'd1, 16'h1111, 2'b01};
    vecs[4]  = '{0, 4'd1, 16'h1111, 1, 4'd2, 16'h2222, 0, 1, 1, 4'd2, 16'h2222, 2'b10};
    vecs[5]  = '{1, 4'd4, 16'h4444, 1, 4'd6, 16'h6666, 1, 0, 1, 4'd4, 16'h4444, 2'b01};
    vecs[6]  = '{1, 4'd4, 16'h4444, 1, 4'd6, 16'h6666, 0, 1, 1, 4'd6, 16'h6666, 2'b10};
    vecs[7]  = '{1, 4'd4, 16'h4444, 1, 4'd6, 16'h6666, 1, 0, 1, 4'd4, 16'h4444, 2'b01};
    vecs[8]  = '{1, 4'd4, 16'h4444, 1, 4'd6, 16'h6666, 0, 1, 1, 4'd6, 16'h6666, 2'b10};
    vecs[9]  = '{1, 4'd4, 16'h4444, 1, 4'd6, 16'h6666, 1, 0, 1, 4'd4, 16'h4444, 2'b01};
    vecs[10] = '{1, 4'd4, 16'h4444, 1, 4'd6, 16'h6666, 0, 1, 1, 4'd6, 16'h6666, 2'b10};
    vecs[11] = '{1, 4'd8, 16'h0808, 0, 4'd0, 16'h0000, 1, 0, 1, 4'd8, 16'h0808, 2'b01};
    vecs[12] = '{1, 4'd5, 16'hAAAA, 1, 4'd5, 16'h5555, 0, 1, 1, 4'd5, 16'h5555, 2'b10};
    vecs[13] = '{1, 4'd5, 16'hAAAA, 0, 4'd5, 16'h5555, 1, 0, 1, 4'd5, 16'hAAAA, 2'b01};
    vecs[14] = '{0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0, 0, 4'd5, 16'hAAAA, 2'b00};

    rst = 1'b1;
    alu_valid = 1'b1; alu_addr = 4'd9; alu_data = 16'hDEAD;
    mem_valid = 1'b1; mem_addr = 4'd10; mem_data = 16'hF00D;
    tick();
    tick();
    #1;
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_alu_ready", 32'(alu_ready), 0);
    chk("rst_mem_ready", 32'(mem_ready), 0);
    rst = 1'b0;
    check_init_seq();

    for (int i = 0; i < 15; i++) begin
      alu_valid = vecs[i].av; alu_addr = vecs[i].aa; alu_data = vecs[i].ad;
      mem_valid = vecs[i].mv; mem_addr = vecs[i].ma; mem_data = vecs[i].md;
      #1;
      chk($sformatf("v%0d_alu_ready", i), 32'(alu_ready), 32'(vecs[i].ear));
      chk($sformatf("v%0d_mem_ready", i), 32'(mem_ready), 32'(vecs[i].emr));
      tick();
      chk($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].ewe));
      chk($sformatf("v%0d_wr_addr", i), 32'(wr_addr), 32'(vecs[i].ewa));
      chk($sformatf("v%0d_wr_data", i), 32'(wr_data), 32'(vecs[i].ewd));
      chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].eg));
    end

    // mid-run reset with both sources requesting
    alu_valid = 1'b1; alu_addr = 4'd11; alu_data = 16'h1234;
    mem_valid = 1'b1; mem_addr = 4'd12; mem_data = 16'h5678;
    rst = 1'b1;
    #1;
    chk("mrst_alu_ready", 32'(alu_ready), 0);
    chk("mrst_mem_ready", 32'(mem_ready), 0);
    tick();
    chk("mrst_wr_en", 32'(wr_en), 0);
    chk("mrst_wr_addr", 32'(wr_addr), 0);
    chk("mrst_wr_data", 32'(wr_data), 0);
    chk("mrst_grant", 32'(grant), 0);
    chk("mrst_init_done", 32'(init_done), 0);
    rst = 1'b0;
    check_init_seq();
    #1;
    chk("post_alu_ready", 32'(alu_ready), 0);
    tick();
    chk("post_wr_en", 32'(wr_en), 0);
    chk("post_grant", 32'(grant), 0);
    chk("post_wr_addr", 32'(wr_addr), 15);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/gpr_wb_arbiter.md
# gpr_wb_arbiter

Write-back arbiter and initialiser for the 16 x 16-bit general-purpose register file. It shares the register file's single write port between the ALU and load/memory write-back sources using a valid/ready handshake with round-robin priority. It drives the 4-bit write address into the GPR address decoder. After every reset it first clears all 16 registers to zero, then hands the port to the requesters.

## Interface
Parameters:
- DATA_W, 16, register data width
- ADDR_W, 4, register address width
- NUM_REGS, 16, registers cleared during init; must equal 2**ADDR_W

Ports:
- CLK  in  1  single clock; all state updates on the rising edge
- RST  in  1  synchronous, active-high reset
- ALU_VALID  in  1  ALU write-back request
- ALU_ADDR  in  ADDR_W  ALU destination register
- ALU_DATA  in  DATA_W  ALU result
- ALU_READY  out  1  ALU request accepted this cycle
- MEM_VALID  in  1  load write-back request
- MEM_ADDR  in  ADDR_W  load destination register
- MEM_DATA  in  DATA_W  load data
- MEM_READY  out  1  load request accepted this cycle
- WR_EN  out  1  register-file write enable (registered)
- WR_ADDR  out  ADDR_W  to GPR address decoder (registered)
- WR_DATA  out  DATA_W  register-file write data (registered)
- GRANT  out  2  one-hot {MEM,ALU}: source of the current WR_* write; 00 for init or idle
- INIT_DONE  out  1  high once all registers have been cleared

## Operation
- States: INIT, RUN.
- While RST is high, the next state is INIT with init counter 0 and priority pointer = ALU. Registered outputs reset to WR_EN=0, WR_ADDR=0, WR_DATA=0, GRANT=00, INIT_DONE=0. ALU_READY and MEM_READY are 0.
- INIT:
  - Each edge writes WR_EN=1, WR_ADDR=counter, WR_DATA=0, GRANT=00, then increments the counter.
  - On the edge that writes address NUM_REGS-1: go to RUN and set INIT_DONE=1.
  - Both READYs are held at 0 throughout INIT.
- RUN:
  - Arbitration is combinational on the VALIDs. At most one READY is high per cycle.
  - If only one source is valid, that source wins.
  - If both are valid, the source named by the priority pointer wins.
  - A handshake occurs when VALID && READY. On that edge, WR_EN=1 and WR_ADDR/WR_DATA/GRANT are taken from the winner.
  - After each handshake, the pointer moves to the non-winning source, including uncontended grants.
  - With no VALID: WR_EN=0 and GRANT=00. WR_ADDR and WR_DATA hold their last values.
- Same destination address from both sources in the same cycle: no merging. The two writes occur in consecutive grants in priority order, so the last-granted data persists.
- A source must hold VALID/ADDR/DATA stable until accepted. The arbiter does not check this.
- READY never depends on the losing source's ADDR/DATA.
- No buffering: a request sits on its source until granted.

## Timing
- Latency: a handshake on edge N produces WR_EN/WR_ADDR/WR_DATA valid after edge N and held through edge N+1. Write-back is one cycle.
- Throughput: one write per cycle.
- Init: with RST deasserted before edge 1, edges 1..16 write addresses 0..15 with data 0. INIT_DONE rises after edge 16. The first READY can be high in the cycle following edge 16. The first user write appears on WR_* after edge 17.
- Fairness: a continuously valid source is granted within 2 consecutive RUN cycles.
- Reset mid-operation (INIT or RUN): on the next edge, all state returns to reset values and no pending write survives. Init restarts from address 0 after RST falls.
- RST held for multiple cycles keeps every output at its reset value.

## Test plan
- Init: release RST; over 16 edges, WR_EN=1 and WR_ADDR steps 0..15 with WR_DATA=0, READYs 0 and GRANT=00 throughout. INIT_DONE=1 after edge 16.
- Single source: after init, ALU_VALID=1, ALU_ADDR=3, ALU_DATA=16'hBEEF for one cycle. Required: ALU_READY=1 that cycle, then WR_EN=1, WR_ADDR=3, WR_DATA=BEEF, GRANT=01 for exactly one cycle. Then WR_EN=0.
- Contention: both valid continuously from reset pointer = ALU, ALU to r1 (16'h1111), MEM to r2 (16'h2222), each dropping VALID once accepted. Required: grants ALU, MEM in consecutive cycles; WR_* sequence r1/1111, r2/2222. MEM_READY=0 while ALU is granted.
- Alternation: both VALIDs held high for 6 cycles. Required: GRANT alternates 01,10,01,10,01,10 with no idle cycle.
- Same address: both target r5 (ALU 16'hAAAA, MEM 16'h5555) with pointer = MEM. Required: MEM write then ALU write, so the final r5 value is AAAA.
- Mid-run reset: assert RST for 1 cycle while both sources are valid. Required: next edge WR_EN=0, INIT_DONE=0, READYs 0. The 16-cycle clear sequence restarts at address 0 and no stale request is written.
